// File: rtl/alu_ram_fetch.sv
// alu_ram_fetch: in-order video RAM fetch stage with a credit-limited return buffer.
// Optional colour-key detection on sprite words is built when ALU_FETCH_COLORKEY_EN is defined.
module alu_ram_fetch #(
  parameter int                ADDR_W     = 26,
  parameter int                DATA_W     = 16,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] COLOR_KEY  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] in_offset,
  input  logic              in_isSprite,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_isSprite,
  output logic              out_transparent,
  output logic              busy,
  output logic              err_unexpected
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, REQ} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              side_q, side_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W:0]    credit_used;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              accept, grant, rv_ok, pop;

  logic [PTR_W-1:0]  sb_wr_q, sb_rd_q, buf_wr_q, buf_rd_q;
  logic              sb_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] dat_q [FIFO_DEPTH];
  logic              spr_q [FIFO_DEPTH];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    side_d     = side_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    err_d      = err_q;
    accept     = in_valid && ready_q;
    grant      = (state_q == REQ) && mem_gnt;
    rv_ok      = mem_rvalid && (inflight_q != '0);
    pop        = (count_q != '0) && out_ready;

    case (state_q)
      IDLE: if (accept) begin
        state_d = REQ;
        addr_d  = in_base + in_offset;
        side_d  = in_isSprite;
      end
      REQ: if (mem_gnt) state_d = IDLE;
    endcase

    case ({grant, rv_ok})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    case ({rv_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (mem_rvalid && (inflight_q == '0)) err_d = 1'b1;

    // A pending request already holds a credit, so ready only opens back up in IDLE.
    credit_used = {1'b0, inflight_d} + {1'b0, count_d};
    ready_d     = (state_d == IDLE) && (credit_used < DEPTH_V);
    busy_d      = (state_d == REQ) || (inflight_d != '0) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      side_q     <= 1'b0;
      inflight_q <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      sb_wr_q    <= '0;
      sb_rd_q    <= '0;
      buf_wr_q   <= '0;
      buf_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      side_q     <= side_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      if (grant) sb_wr_q  <= sb_wr_q + 1'b1;
      if (rv_ok) sb_rd_q  <= sb_rd_q + 1'b1;
      if (rv_ok) buf_wr_q <= buf_wr_q + 1'b1;
      if (pop)   buf_rd_q <= buf_rd_q + 1'b1;
    end
  end

  // Storage arrays carry data only; validity lives in the reset pointers and counters.
  always_ff @(posedge clk) begin
    if (grant) sb_q[sb_wr_q] <= side_q;
    if (rv_ok) begin
      dat_q[buf_wr_q] <= mem_rdata;
      spr_q[buf_wr_q] <= sb_q[sb_rd_q];
    end
  end

  assign in_ready       = ready_q;
  assign mem_req        = (state_q == REQ);
  assign mem_addr       = addr_q;
  assign out_valid      = (count_q != '0);
  assign out_data       = out_valid ? dat_q[buf_rd_q] : '0;
  assign out_isSprite   = out_valid && spr_q[buf_rd_q];
  assign busy           = busy_q;
  assign err_unexpected = err_q;

`ifdef ALU_FETCH_COLORKEY_EN
  logic trn_q [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (rv_ok) trn_q[buf_wr_q] <= sb_q[sb_rd_q] && (mem_rdata == COLOR_KEY);
  end

  assign out_transparent = out_valid && trn_q[buf_rd_q];
`else
  logic unused_key;
  assign unused_key      = ^COLOR_KEY;
  assign out_transparent = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ram_fetch.sv
// Bench for alu_ram_fetch: directed scenarios plus randomized traffic against a queue-based model.
module tb_alu_ram_fetch;

`ifdef ALU_FETCH_COLORKEY_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_isSprite;
  logic [25:0] in_base, in_offset, mem_addr;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [15:0] mem_rdata, out_data;
  logic        out_valid, out_ready, out_isSprite, out_transparent, busy, err_unexpected;

  int checks = 0;
  int errors = 0;

  alu_ram_fetch dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_base(in_base), .in_offset(in_offset), .in_isSprite(in_isSprite),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_isSprite(out_isSprite), .out_transparent(out_transparent),
    .busy(busy), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_fetch(input logic [25:0] b, input logic [25:0] o, input logic s,
                             input logic [15:0] d);
    in_valid = 1'b1; in_base = b; in_offset = o; in_isSprite = s;
    tick();
    in_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = d;
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
    checks++; if (mem_req !== 1'b0 || mem_addr !== 26'h0) begin errors++; $display("FAIL reset_mem: got req %b addr %h exp 0 0", mem_req, mem_addr); end
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0 || out_isSprite !== 1'b0 || out_transparent !== 1'b0) begin
      errors++; $display("FAIL reset_out: got v %b d %h s %b t %b exp all 0", out_valid, out_data, out_isSprite, out_transparent); end
    checks++; if (busy !== 1'b0 || err_unexpected !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy %b err %b exp 0 0", busy, err_unexpected); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_single_fetch();
    in_valid = 1'b1; in_base = 26'h100; in_offset = 26'h20; in_isSprite = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 26'h120) begin errors++; $display("FAIL single_req: got req %b addr %h exp 1 120", mem_req, mem_addr); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_req_flags: got ready %b busy %b exp 0 1", in_ready, busy); end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checks++; if (mem_req !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL single_after_gnt: got req %b ready %b exp 0 1", mem_req, in_ready); end
    tick();
    tick();
    mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b exp 0", out_valid); end
    tick();
    mem_rvalid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_isSprite !== 1'b1) begin
      errors++; $display("FAIL single_out: got v %b d %h s %b exp 1 beef 1", out_valid, out_data, out_isSprite); end
    checks++; if (out_transparent !== 1'b0) begin errors++; $display("FAIL single_trn: got %b exp 0", out_transparent); end
    pop_one();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_drained: got v %b busy %b exp 0 0", out_valid, busy); end
  endtask

  task automatic test_wrap();
    in_valid = 1'b1; in_base = 26'h3FFFFFF; in_offset = 26'h2; in_isSprite = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 26'h0000001) begin errors++; $display("FAIL wrap_addr: got req %b addr %h exp 1 0000001", mem_req, mem_addr); end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hCAFE;
    tick();
    mem_rvalid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hCAFE || out_isSprite !== 1'b0) begin
      errors++; $display("FAIL wrap_out: got v %b d %h s %b exp 1 cafe 0", out_valid, out_data, out_isSprite); end
    pop_one();
  endtask

  task automatic test_credit_limit();
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL credit_ready_before_%0d: got %b exp 1", i, in_ready); end
      in_valid = 1'b1; in_base = 26'h400; in_offset = 26'(i); in_isSprite = i[0];
      tick();
      in_valid = 1'b0; mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hA000 + 16'(i);
      if (i == 3) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL credit_full_at_grant: got %b exp 0", in_ready); end
      end
      tick();
      mem_rvalid = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL credit_hold_%0d: got ready %b valid %b exp 0 1", k, in_ready, out_valid); end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 16'hA000 + 16'(i) || out_isSprite !== i[0]) begin
        errors++; $display("FAIL credit_pop_%0d: got v %b d %h s %b exp 1 %h %b", i, out_valid, out_data, out_isSprite, 16'hA000 + 16'(i), i[0]); end
      pop_one();
      if (i == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL credit_reopen: got %b exp 1", in_ready); end
      end
    end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL credit_empty: got v %b busy %b exp 0 0", out_valid, busy); end
  endtask

  task automatic test_simultaneous();
    in_valid = 1'b1; in_base = 26'h200; in_offset = 26'h1; in_isSprite = 1'b0;
    tick();
    in_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h1111;
    in_valid = 1'b1; in_offset = 26'h2; in_isSprite = 1'b1;
    tick();
    mem_rvalid = 1'b0; in_valid = 1'b0; mem_gnt = 1'b1;
    checks++; if (mem_addr !== 26'h202) begin errors++; $display("FAIL simul_addr_b: got %h exp 202", mem_addr); end
    tick();
    mem_gnt = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL simul_ready_c: got %b exp 1", in_ready); end
    in_valid = 1'b1; in_offset = 26'h3; in_isSprite = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (mem_req !== 1'b1 || out_valid !== 1'b1 || out_data !== 16'h1111) begin
      errors++; $display("FAIL simul_pre: got req %b v %b d %h exp 1 1 1111", mem_req, out_valid, out_data); end
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h2222; out_ready = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h3333; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h2222 || out_isSprite !== 1'b1 || in_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL simul_post: got v %b d %h s %b ready %b req %b exp 1 2222 1 1 0", out_valid, out_data, out_isSprite, in_ready, mem_req); end
    tick();
    mem_rvalid = 1'b0; out_ready = 1'b1;
    checks++; if (out_data !== 16'h2222) begin errors++; $display("FAIL simul_hold: got %h exp 2222", out_data); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h3333 || out_isSprite !== 1'b0) begin
      errors++; $display("FAIL simul_last: got v %b d %h s %b exp 1 3333 0", out_valid, out_data, out_isSprite); end
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || err_unexpected !== 1'b0) begin
      errors++; $display("FAIL simul_end: got v %b busy %b err %b exp 0 0 0", out_valid, busy, err_unexpected); end
  endtask

  task automatic test_unexpected();
    mem_rvalid = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_rvalid = 1'b0;
    checks++; if (out_valid !== 1'b0 || err_unexpected !== 1'b1) begin errors++; $display("FAIL unexp_set: got v %b err %b exp 0 1", out_valid, err_unexpected); end
    tick(); tick(); tick();
    checks++; if (err_unexpected !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL unexp_sticky: got err %b v %b exp 1 0", err_unexpected, out_valid); end
    rst_n = 1'b0;
    tick();
    checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL unexp_clear: got %b exp 0", err_unexpected); end
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_base = 26'h0; in_offset = 26'h5; in_isSprite = 1'b1;
    tick();
    in_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL midreset_state: got req %b busy %b ready %b exp 0 0 0", mem_req, busy, in_ready); end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 16'h5555;
    tick();
    mem_rvalid = 1'b0;
    checks++; if (err_unexpected !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midreset_stale: got err %b v %b exp 1 0", err_unexpected, out_valid); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_colorkey();
    issue_fetch(26'h300, 26'h0, 1'b1, 16'h0000);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_transparent !== CK_EN) begin
      errors++; $display("FAIL ck_sprite_key: got v %b d %h t %b exp 1 0000 %b", out_valid, out_data, out_transparent, CK_EN); end
    pop_one();
    issue_fetch(26'h300, 26'h1, 1'b0, 16'h0000);
    checks++; if (out_valid !== 1'b1 || out_isSprite !== 1'b0 || out_transparent !== 1'b0) begin
      errors++; $display("FAIL ck_char_key: got v %b s %b t %b exp 1 0 0", out_valid, out_isSprite, out_transparent); end
    pop_one();
    issue_fetch(26'h300, 26'h2, 1'b1, 16'h00F0);
    checks++; if (out_valid !== 1'b1 || out_transparent !== 1'b0) begin errors++; $display("FAIL ck_sprite_nokey: got v %b t %b exp 1 0", out_valid, out_transparent); end
    pop_one();
  endtask

  typedef struct { logic [15:0] data; logic spr; int due; } rd_t;
  typedef struct { logic [15:0] data; logic spr; } ow_t;

  task automatic test_random(input int ncyc);
    rd_t r;
    ow_t o;
    rd_t rd_q[$];
    ow_t out_q[$];
    logic pend, pend_spr, exp_ready, exp_ov, exp_t, rv, drain;
    logic [25:0] pend_addr;
    int outstanding;
    pend = 1'b0; pend_spr = 1'b0; pend_addr = '0; outstanding = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int cyc = 0; cyc < ncyc + 60; cyc++) begin
      drain     = (cyc >= ncyc);
      exp_ready = !pend && (outstanding < 4);
      exp_ov    = (out_q.size() != 0);
      checks++; if (mem_req !== pend) begin errors++; $display("FAIL rand_req c%0d: got %b exp %b", cyc, mem_req, pend); end
      if (pend) begin
        checks++; if (mem_addr !== pend_addr) begin errors++; $display("FAIL rand_addr c%0d: got %h exp %h", cyc, mem_addr, pend_addr); end
      end
      checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c%0d: got %b exp %b", cyc, in_ready, exp_ready); end
      checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL rand_valid c%0d: got %b exp %b", cyc, out_valid, exp_ov); end
      if (exp_ov) begin
        exp_t = CK_EN && out_q[0].spr && (out_q[0].data == 16'h0000);
        checks++; if (out_data !== out_q[0].data || out_isSprite !== out_q[0].spr || out_transparent !== exp_t) begin
          errors++; $display("FAIL rand_data c%0d: got %h %b %b exp %h %b %b", cyc, out_data, out_isSprite, out_transparent, out_q[0].data, out_q[0].spr, exp_t); end
      end
      in_valid    = !drain && ($urandom_range(0, 1) == 1);
      in_base     = 26'($urandom);
      in_offset   = 26'($urandom);
      in_isSprite = 1'($urandom);
      mem_gnt     = pend && ($urandom_range(0, 2) != 0);
      rv          = (rd_q.size() != 0) && (rd_q[0].due <= cyc) && ($urandom_range(0, 3) != 0);
      mem_rvalid  = rv;
      mem_rdata   = rv ? rd_q[0].data : 16'($urandom);
      out_ready   = drain || (((cyc % 80) >= 25) && ($urandom_range(0, 2) != 0));
      if (exp_ov && out_ready) begin
        void'(out_q.pop_front());
        outstanding--;
      end
      if (rv) begin
        r = rd_q.pop_front();
        o.data = r.data; o.spr = r.spr;
        out_q.push_back(o);
      end
      if (mem_gnt) begin
        r.data = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        r.spr  = pend_spr;
        r.due  = cyc + 1 + int'($urandom_range(0, 4));
        rd_q.push_back(r);
        pend = 1'b0;
      end
      if (in_valid && exp_ready) begin
        pend = 1'b1; pend_addr = in_base + in_offset; pend_spr = in_isSprite;
        outstanding++;
      end
      tick();
    end
    in_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; out_ready = 1'b0;
    checks++; if (out_q.size() != 0 || rd_q.size() != 0 || busy !== 1'b0 || err_unexpected !== 1'b0) begin
      errors++; $display("FAIL rand_drain: got outq %0d rdq %0d busy %b err %b exp 0 0 0 0", out_q.size(), rd_q.size(), busy, err_unexpected); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_base = '0; in_offset = '0; in_isSprite = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
    test_reset();
    test_single_fetch();
    test_wrap();
    test_credit_limit();
    test_simultaneous();
    test_unexpected();
    test_colorkey();
    test_random(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ram_fetch.md
# alu_ram_fetch

Pipe-2 memory fetch stage directly downstream of the ALU address calculator. Takes a 26-bit address offset (sprite pixel or character pair) plus the object's base address, issues in-order read requests to the shared video RAM port, and buffers the returned 16-bit words for the next pipe stage. Uses a credit scheme so returned data can never overflow the local buffer, and supports multiple reads in flight.

## Interface
- ADDR_W, 26, RAM word address width; equals the address calculator's offset width
- DATA_W, 16, RAM data width
- FIFO_DEPTH, 4, return-buffer entries and maximum reads in flight; power of two, 2..16
- COLOR_KEY, 16'h0000, transparent sprite value; used only with ALU_FETCH_COLORKEY_EN

- clk  in  1  pipeline clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid && in_ready
- in_base  in  ADDR_W  object base address in RAM
- in_offset  in  ADDR_W  unsigned offset from the address calculator
- in_isSprite  in  1  1 = sprite pixel, 0 = character pair; carried as sideband
- mem_req  out  1  read request; held until granted
- mem_addr  out  ADDR_W  read address; stable while mem_req is high
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid; returns in request order
- mem_rdata  in  DATA_W  read data
- out_valid  out  1  buffered word available
- out_ready  in  1  downstream takes the word when out_valid && out_ready
- out_data  out  DATA_W  fetched word
- out_isSprite  out  1  sideband matching out_data
- out_transparent  out  1  colour-key hit; see Configuration
- busy  out  1  request pending, reads in flight, or buffer not empty
- err_unexpected  out  1  sticky flag for mem_rvalid with no read in flight

## Operation
- Clock and reset: single clock, `clk`. Reset is `rst_n`, synchronous and active-low.
- Address calculation: mem_addr = (in_base + in_offset) mod 2^ADDR_W, registered when the command is accepted. Wrap-around is silent.
- Request register: one pending request with states IDLE and REQ.
  - IDLE -> REQ on command accept.
  - REQ -> IDLE on mem_gnt.
  - There is no REQ -> REQ back-to-back path. in_ready is low whenever the state is REQ.
- Credits:
  - inflight counts granted reads whose data has not yet returned.
  - count is the number of buffer entries.
  - in_ready = (state == IDLE) && (inflight + count < FIFO_DEPTH).
  - The pending request reserves its credit from acceptance onward.
- Sideband FIFO: depth FIFO_DEPTH. The in_isSprite value is pushed on mem_gnt and popped on mem_rvalid. It is written into the data buffer together with mem_rdata.
- Data buffer:
  - Push on mem_rvalid when inflight > 0.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop leaves count unchanged.
- inflight update: +1 on grant and −1 on accepted rvalid. Both in the same cycle leaves it unchanged.
- Unexpected return: mem_rvalid while inflight == 0 is dropped, nothing is pushed, and err_unexpected is set. It clears only on reset.
- Reset values:
  - in_ready 0 during reset, 1 the cycle after reset releases.
  - mem_req 0, mem_addr 0, out_valid 0, out_data 0, out_isSprite 0, out_transparent 0, busy 0, err_unexpected 0.
- Reset mid-operation: the pending request, in-flight count and buffer are discarded. Any mem_rvalid from pre-reset reads that arrives after reset raises err_unexpected. The system resets the RAM arbiter together with this block.

## Timing
- Command accepted in cycle N: mem_req is high in N+1.
- Grant in cycle G: mem_req is low in G+1, and in_ready can be high in G+1.
- mem_rvalid in cycle R: out_valid is high in R+1, so the buffer adds one cycle of latency. out_data is registered.
- Best-case throughput is one command every 2 cycles, limited by IDLE/REQ alternation.
- busy is a registered OR of state==REQ, inflight != 0 and count != 0.

## Configuration
- ALU_FETCH_COLORKEY_EN defined: out_transparent = out_isSprite && (out_data == COLOR_KEY), registered alongside out_data.
- ALU_FETCH_COLORKEY_EN undefined: out_transparent is tied to 0 and the comparator is not built.

## Test plan
- Single fetch: base 0x100, offset 0x20, gnt in the first REQ cycle, rvalid 3 cycles later with 0xBEEF -> mem_addr 0x120; out_valid 1 cycle after rvalid with 0xBEEF and matching out_isSprite.
- Wrap: base 0x3FFFFFF, offset 2 -> mem_addr 0x0000001.
- Credit limit: out_ready held 0, 4 commands returned -> in_ready stays 0 after the 4th grant. One pop -> in_ready returns to 1 the next cycle.
- Simultaneous events: grant of command k in the same cycle as rvalid of command k-1, with a pop in that cycle -> inflight and count unchanged, data order preserved.
- Unexpected rvalid at idle -> nothing output, err_unexpected set and held until rst_n low.
- Colour key: with the macro defined, a sprite word 0x0000 -> out_transparent 1; the same word with isSprite=0 -> 0. With the macro undefined -> always 0.
